// File: rtl/csa_pipelined_subtractor_pkg.sv
// ============================================================================
//  Module   : csa_pkg
//  Brief    : Shared constants, block-count helper and the per-block
//             candidate record for the pipelined carry-select subtractor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package csa_pkg;

    // Default operand and ripple-block widths
    localparam int c_DEFAULT_WIDTH = 16;
    localparam int c_DEFAULT_BLOCK = 8;

    // Number of ripple blocks covering an operand
    function automatic int nblk(input int width, input int block);
        return width / block;
    endfunction

    // Both speculative results of one ripple block: borrow-in 0 and borrow-in 1.
    // Its field width fixes the block width the top can be built with.
    typedef struct packed {
        logic [c_DEFAULT_BLOCK-1:0] diff0;
        logic [c_DEFAULT_BLOCK-1:0] diff1;
        logic                       bo0;
        logic                       bo1;
    } blk_cand_t;

endpackage

`default_nettype wire

// File: rtl/csa_pipelined_subtractor_rcs_block.sv
// ============================================================================
//  Module   : rcs_block
//  Brief    : Combinational BLOCK-bit ripple subtractor, d = a - b - bin,
//             with borrow out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rcs_block
    import csa_pkg::*;
#(
    parameter int BLOCK = c_DEFAULT_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             bin,
    output logic [BLOCK-1:0] d,
    output logic             bout
);

    logic [BLOCK:0] w_br;

    // Bit-serial borrow ripple: borrow out when a < b + borrow-in at each bit
    always_comb begin
        w_br    = '0;
        d       = '0;
        w_br[0] = bin;
        for (int i = 0; i < BLOCK; i++) begin
            d[i]      = a[i] ^ b[i] ^ w_br[i];
            w_br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_br[i]);
        end
    end

    assign bout = w_br[BLOCK];

endmodule

`default_nettype wire

// File: rtl/csa_pipelined_subtractor.sv
// ============================================================================
//  Module   : csa_pipelined_subtractor
//  Brief    : Two-stage pipelined carry-select subtractor, Diff = A - B - Bin,
//             with valid/ready handshake on both sides.
//             Stage 1 registers both borrow candidates of every block; stage 2
//             resolves the borrow-select chain and registers Diff/Bout/Ovf.
//  Config   : define CSA_SUB_SATURATE_EN to clamp Diff on signed overflow.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_pipelined_subtractor
    import csa_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int BLOCK = c_DEFAULT_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    localparam int c_NBLK = nblk(WIDTH, BLOCK);
    localparam int c_MSB  = WIDTH - 1;

    // ------------------------------------------------------------------
    // Speculative block results from the raw operands
    // ------------------------------------------------------------------
    blk_cand_t w_cand [c_NBLK];

    generate
        for (genvar gi = 0; gi < c_NBLK; gi++) begin : g_blk
            logic [BLOCK-1:0] w_d0;
            logic [BLOCK-1:0] w_d1;
            logic             w_b0;
            logic             w_b1;

            rcs_block #(.BLOCK(BLOCK)) u_bin0 (
                .a    (A[gi*BLOCK +: BLOCK]),
                .b    (B[gi*BLOCK +: BLOCK]),
                .bin  (1'b0),
                .d    (w_d0),
                .bout (w_b0)
            );

            rcs_block #(.BLOCK(BLOCK)) u_bin1 (
                .a    (A[gi*BLOCK +: BLOCK]),
                .b    (B[gi*BLOCK +: BLOCK]),
                .bin  (1'b1),
                .d    (w_d1),
                .bout (w_b1)
            );

            assign w_cand[gi] = '{diff0: w_d0, diff1: w_d1, bo0: w_b0, bo1: w_b1};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic             r_s1_valid_q, w_s1_valid_d;
    blk_cand_t        r_s1_cand_q [c_NBLK];
    blk_cand_t        w_s1_cand_d [c_NBLK];
    logic             r_s1_bin_q,   w_s1_bin_d;
    logic             r_s1_amsb_q,  w_s1_amsb_d;
    logic             r_s1_bmsb_q,  w_s1_bmsb_d;

    logic             r_out_valid_q, w_out_valid_d;
    logic [WIDTH-1:0] r_diff_q,      w_diff_d;
    logic             r_bout_q,      w_bout_d;
    logic             r_ovf_q,       w_ovf_d;

    // ------------------------------------------------------------------
    // Handshake: S2 moves when empty or drained; S1 moves when S2 makes room
    // ------------------------------------------------------------------
    logic w_s2_adv;
    logic w_in_ready;

    assign w_s2_adv   = !r_out_valid_q || out_ready;
    assign w_in_ready = !r_s1_valid_q || w_s2_adv;

    // ------------------------------------------------------------------
    // Borrow-select chain over the registered candidates
    // ------------------------------------------------------------------
    logic [c_NBLK:0]  w_sel_br;
    logic [WIDTH-1:0] w_raw_diff;
    logic             w_raw_ovf;
    logic [WIDTH-1:0] w_res_diff;

    // Bin picks block 0; each block's chosen borrow picks the next block
    always_comb begin
        w_sel_br    = '0;
        w_raw_diff  = '0;
        w_sel_br[0] = r_s1_bin_q;
        for (int i = 0; i < c_NBLK; i++) begin
            w_raw_diff[i*BLOCK +: BLOCK] = w_sel_br[i] ? r_s1_cand_q[i].diff1
                                                       : r_s1_cand_q[i].diff0;
            w_sel_br[i+1]                = w_sel_br[i] ? r_s1_cand_q[i].bo1
                                                       : r_s1_cand_q[i].bo0;
        end
    end

    // Signed overflow: operands of opposite sign and result sign differs from A
    assign w_raw_ovf = (r_s1_amsb_q != r_s1_bmsb_q) && (w_raw_diff[c_MSB] != r_s1_amsb_q);

`ifdef CSA_SUB_SATURATE_EN
    // Clamp toward the sign of A on overflow; Bout stays the raw unsigned borrow
    always_comb begin
        w_res_diff = w_raw_diff;
        if (w_raw_ovf) begin
            w_res_diff = r_s1_amsb_q ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_res_diff = w_raw_diff;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // S1 loads on an input transfer, empties when open with no input, else holds
    always_comb begin
        w_s1_valid_d = r_s1_valid_q;
        w_s1_cand_d  = r_s1_cand_q;
        w_s1_bin_d   = r_s1_bin_q;
        w_s1_amsb_d  = r_s1_amsb_q;
        w_s1_bmsb_d  = r_s1_bmsb_q;
        if (w_in_ready) begin
            w_s1_valid_d = in_valid;
            if (in_valid) begin
                w_s1_cand_d = w_cand;
                w_s1_bin_d  = Bin;
                w_s1_amsb_d = A[c_MSB];
                w_s1_bmsb_d = B[c_MSB];
            end
        end
    end

    // S2 takes the resolved result when it may advance; frozen under stall
    always_comb begin
        w_out_valid_d = r_out_valid_q;
        w_diff_d      = r_diff_q;
        w_bout_d      = r_bout_q;
        w_ovf_d       = r_ovf_q;
        if (w_s2_adv) begin
            w_out_valid_d = r_s1_valid_q;
            if (r_s1_valid_q) begin
                w_diff_d = w_res_diff;
                w_bout_d = w_sel_br[c_NBLK];
                w_ovf_d  = w_raw_ovf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Pipeline registers with synchronous reset discarding both stages
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid_q  <= 1'b0;
            for (int i = 0; i < c_NBLK; i++) begin
                r_s1_cand_q[i] <= '0;
            end
            r_s1_bin_q    <= 1'b0;
            r_s1_amsb_q   <= 1'b0;
            r_s1_bmsb_q   <= 1'b0;
            r_out_valid_q <= 1'b0;
            r_diff_q      <= '0;
            r_bout_q      <= 1'b0;
            r_ovf_q       <= 1'b0;
        end else begin
            r_s1_valid_q  <= w_s1_valid_d;
            r_s1_cand_q   <= w_s1_cand_d;
            r_s1_bin_q    <= w_s1_bin_d;
            r_s1_amsb_q   <= w_s1_amsb_d;
            r_s1_bmsb_q   <= w_s1_bmsb_d;
            r_out_valid_q <= w_out_valid_d;
            r_diff_q      <= w_diff_d;
            r_bout_q      <= w_bout_d;
            r_ovf_q       <= w_ovf_d;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid_q;
    assign Diff      = r_diff_q;
    assign Bout      = r_bout_q;
    assign Ovf       = r_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_csa_pipelined_subtractor.sv
// ============================================================================
//  Module   : tb_csa_pipelined_subtractor
//  Brief    : Self-checking bench for csa_pipelined_subtractor: directed
//             vector table, reset/back-pressure sequences and a random soak
//             against a behavioural scoreboard.
//  Config   : honours CSA_SUB_SATURATE_EN in its expected values.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csa_pipelined_subtractor;

    localparam int W = 16;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] A         = '0;
    logic [W-1:0] B         = '0;
    logic         Bin       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         Ovf;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_recv   = 0;
    bit   sb_en    = 1'b0;
    logic [17:0] exp_q [$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    csa_pipelined_subtractor #(.WIDTH(16), .BLOCK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .Ovf       (Ovf)
    );

    // Behavioural reference: {Ovf, Bout, Diff}
    function automatic logic [17:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic bi);
        logic [W:0]   r;
        logic [W-1:0] d;
        logic         o;
        r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        d = r[W-1:0];
        o = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
`ifdef CSA_SUB_SATURATE_EN
        if (o) d = a[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return {o, r[W], d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, report whether the next edge transfers in
    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bi, input logic ordy, output logic acc);
        @(negedge clk);
        in_valid  = v;
        A         = a;
        B         = b;
        Bin       = bi;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc && sb_en) exp_q.push_back(model(a, b, bi));
    endtask

    // Output scoreboard, sampled just before each rising edge
    initial begin : monitor
        logic [17:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (sb_en && !rst && out_valid && out_ready) begin
                n_recv++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: got 0x%0h, expected no output", {Ovf, Bout, Diff});
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_result", {14'd0, Ovf, Bout, Diff}, {14'd0, e});
                end
            end
        end
    end

    initial begin : main
        logic acc;
        logic seen;
        int   nxt;

        // Directed vectors with hand-computed results
        tbl[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[1]  = '{16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0};
        tbl[2]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[3]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        tbl[4]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[5]  = '{16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[6]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        tbl[7]  = '{16'hFFFF, 16'h0001, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        tbl[8]  = '{16'h0100, 16'h0000, 1'b1, 16'h00FF, 1'b0, 1'b0};
        tbl[9]  = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};
        tbl[10] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
        tbl[11] = '{16'h1234, 16'hABCD, 1'b1, 16'h6666, 1'b1, 1'b0};
`ifdef CSA_SUB_SATURATE_EN
        tbl[3].diff = 16'h8000;
        tbl[6].diff = 16'h7FFF;
        tbl[9].diff = 16'h8000;
`endif

        // Reset held 3 cycles with valid input present
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst = 1'b1; in_valid = 1'b1; A = 16'hFFFF; B = 16'h0001; Bin = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", Diff, 0);
        chk("rst_bout", Bout, 0);
        chk("rst_ovf", Ovf, 0);
        chk("rst_in_ready", in_ready, 1);

        // Table: one vector at a time, checking exact 2-cycle latency
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].bin, 1'b1, acc);
            chk("vec_accept", acc, 1);
            cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
            chk("vec_latency_early", out_valid, 0);
            cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
            chk("vec_latency_valid", out_valid, 1);
            chk("vec_result", {Ovf, Bout, Diff}, {tbl[i].ovf, tbl[i].bout, tbl[i].diff});
            cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
        end

        // Reset while an operation is in flight: nothing may emerge
        cycle(1'b1, 16'h4321, 16'h1111, 1'b0, 1'b1, acc);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
            if (out_valid) seen = 1'b1;
        end
        chk("midop_reset_flush", seen, 0);
        chk("midop_reset_diff", Diff, 0);

        // Back-pressure: 4 vectors, out_ready low for 3 stalled cycles
        sb_en  = 1'b1;
        n_recv = 0;
        cycle(1'b1, tbl[0].a, tbl[0].b, tbl[0].bin, 1'b0, acc);
        chk("bp_accept0", acc, 1);
        cycle(1'b1, tbl[1].a, tbl[1].b, tbl[1].bin, 1'b0, acc);
        chk("bp_in_ready_s2_empty", acc, 1);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, tbl[2].a, tbl[2].b, tbl[2].bin, 1'b0, acc);
            chk("bp_in_ready_full", acc, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_frozen", {Ovf, Bout, Diff}, {tbl[0].ovf, tbl[0].bout, tbl[0].diff});
        end
        nxt = 2;
        for (int g = 0; g < 20 && nxt < 4; g++) begin
            cycle(1'b1, tbl[nxt].a, tbl[nxt].b, tbl[nxt].bin, 1'b1, acc);
            if (acc) nxt++;
        end
        chk("bp_all_sent", nxt, 4);
        for (int g = 0; g < 20 && exp_q.size() != 0; g++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_recv_count", n_recv, 4);

        // Random soak with random valid and back-pressure
        begin
            logic         have;
            logic [W-1:0] ra, rb;
            logic         rbi;
            have = 1'b0; ra = '0; rb = '0; rbi = 1'b0;
            n_recv = 0;
            for (int it = 0; it < 10000; it++) begin
                if (!have) begin
                    case ($urandom_range(0, 7))
                        0:       ra = 16'h8000;
                        1:       ra = 16'h0000;
                        2:       ra = 16'h7FFF;
                        default: ra = 16'($urandom);
                    endcase
                    case ($urandom_range(0, 7))
                        0:       rb = 16'hFFFF;
                        1:       rb = 16'h0001;
                        2:       rb = ra;
                        default: rb = 16'($urandom);
                    endcase
                    rbi  = 1'($urandom_range(0, 1));
                    have = 1'b1;
                end
                cycle($urandom_range(0, 3) != 0, ra, rb, rbi, $urandom_range(0, 3) != 0, acc);
                if (acc) have = 1'b0;
            end
            for (int g = 0; g < 20 && exp_q.size() != 0; g++) begin
                cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
            end
            cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
            chk("soak_drained", exp_q.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
